// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared state encoding, default pattern and width constants
package seq_scan_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
  localparam int DEF_NCH = 4;
  localparam int DEF_W = 16;
  localparam int DEF_PLEN = 4;
  localparam logic [DEF_PLEN-1:0] DEF_PATTERN = 4'b1011;
  localparam int CW = $clog2(DEF_W + 1);
  localparam int PW = $clog2(DEF_W);
  localparam int IW = $clog2(DEF_NCH);
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: serial Mealy matcher, flags a match on the bit completing PATTERN
module seq_match_core
  import seq_scan_pkg::*;
#(
  parameter int PLEN = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic bit_in,
  input  logic bit_en,
  output logic match
);
  localparam int HW = PLEN - 1;
  localparam int FW = $clog2(PLEN);
  logic [HW-1:0] hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  // fill counter blocks matches until PLEN-1 real bits are in history
  always_comb begin
    hist_d = clr ? '0 : bit_en ? HW'({hist_q, bit_in}) : hist_q;
    fill_d = clr ? '0 : (bit_en && fill_q != FW'(HW)) ? fill_q + FW'(1) : fill_q;
    match = bit_en && fill_q == FW'(HW) && {hist_q, bit_in} == PATTERN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end
endmodule

// File: rtl/seq_scan_sched.sv
// seq_scan_sched: round-robin scheduler serialising channel words into one
// pattern-match core and reporting count / first-match position per word
module seq_scan_sched
  import seq_scan_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int W = DEF_W,
  parameter int PLEN = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN,
  localparam int CNT_W = $clog2(W + 1),
  localparam int POS_W = $clog2(W),
  localparam int CH_W = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   req_valid,
  input  logic [NCH*W-1:0] req_data,
  output logic [NCH-1:0]   req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [CH_W-1:0]  rsp_chan,
  output logic [CNT_W-1:0] rsp_count,
  output logic             rsp_hit,
  output logic [POS_W-1:0] rsp_first,
  output logic             busy
);
  state_t state_q, state_d;
  logic [CH_W-1:0] rr_q, rr_d, chan_q, chan_d, rsp_chan_q, rsp_chan_d, gnt;
  logic [W-1:0] word_q, word_d;
  logic [POS_W-1:0] k_q, k_d, first_q, first_d, rsp_first_q, rsp_first_d, first_nx;
  logic [CNT_W-1:0] cnt_q, cnt_d, rsp_count_q, rsp_count_d, cnt_nx;
  logic rsp_hit_q, rsp_hit_d, gnt_ok, take, match;
  // descending scan so the lowest offset from rr_q wins
  always_comb begin
    gnt = '0;
    gnt_ok = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_valid[(int'(rr_q) + i) % NCH]) begin
        gnt = CH_W'((int'(rr_q) + i) % NCH);
        gnt_ok = 1'b1;
      end
    end
  end
  assign take = state_q == IDLE && gnt_ok && !reset;
  assign req_ready = take ? NCH'(1) << gnt : '0;
  assign rsp_valid = state_q == RESP;
  assign busy = state_q != IDLE;
  assign rsp_chan = rsp_chan_q;
  assign rsp_count = rsp_count_q;
  assign rsp_hit = rsp_hit_q;
  assign rsp_first = rsp_first_q;
  assign cnt_nx = cnt_q + CNT_W'(match);
  assign first_nx = (match && cnt_q == '0) ? k_q : first_q;
  seq_match_core #(.PLEN(PLEN), .PATTERN(PATTERN)) u_core (
    .clk(clk), .reset(reset), .clr(take), .bit_in(word_q[W-1]),
    .bit_en(state_q == SHIFT), .match(match)
  );
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    chan_d = chan_q;
    word_d = word_q;
    k_d = k_q;
    cnt_d = cnt_q;
    first_d = first_q;
    rsp_chan_d = rsp_chan_q;
    rsp_count_d = rsp_count_q;
    rsp_hit_d = rsp_hit_q;
    rsp_first_d = rsp_first_q;
    case (state_q)
      IDLE: if (take) begin
        state_d = SHIFT;
        chan_d = gnt;
        word_d = req_data[int'(gnt)*W +: W];
        k_d = '0;
        cnt_d = '0;
        first_d = '0;
      end
      SHIFT: begin
        word_d = word_q << 1;
        k_d = k_q + POS_W'(1);
        cnt_d = cnt_nx;
        first_d = first_nx;
        if (k_q == POS_W'(W - 1)) begin
          state_d = RESP;
          rsp_chan_d = chan_q;
          rsp_count_d = cnt_nx;
          rsp_hit_d = cnt_nx != '0;
          rsp_first_d = first_nx;
        end
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        rr_d = chan_q == CH_W'(NCH - 1) ? '0 : chan_q + CH_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q <= '0;
      chan_q <= '0;
      word_q <= '0;
      k_q <= '0;
      cnt_q <= '0;
      first_q <= '0;
      rsp_chan_q <= '0;
      rsp_count_q <= '0;
      rsp_hit_q <= 1'b0;
      rsp_first_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      chan_q <= chan_d;
      word_q <= word_d;
      k_q <= k_d;
      cnt_q <= cnt_d;
      first_q <= first_d;
      rsp_chan_q <= rsp_chan_d;
      rsp_count_q <= rsp_count_d;
      rsp_hit_q <= rsp_hit_d;
      rsp_first_q <= rsp_first_d;
    end
  end
endmodule

// File: tb/tb_seq_scan_sched.sv
// tb_seq_scan_sched: directed and random stimulus against a behavioural model
module tb_seq_scan_sched;
  import seq_scan_pkg::*;
  localparam int NCH = 4, W = 16, PLEN = 4;
  localparam logic [PLEN-1:0] PAT = 4'b1011;
  logic clk = 1'b0, reset, rsp_ready, rsp_valid, rsp_hit, busy;
  logic [NCH-1:0] req_valid, req_ready;
  logic [NCH*W-1:0] req_data;
  logic [IW-1:0] rsp_chan;
  logic [CW-1:0] rsp_count;
  logic [PW-1:0] rsp_first;
  int n_vec = 0, n_bad = 0;
  int m_state, m_k, m_rr, m_chan;
  logic [W-1:0] m_word;
  logic [IW-1:0] e_chan;
  logic [CW-1:0] e_count;
  logic e_hit;
  logic [PW-1:0] e_first;
  seq_scan_sched dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_chan(rsp_chan), .rsp_count(rsp_count), .rsp_hit(rsp_hit),
    .rsp_first(rsp_first), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Sliding-window count over the word, bit index 0 = MSB
  function automatic void scan(input logic [W-1:0] w, output int cnt, output int first);
    cnt = 0;
    first = 0;
    for (int k = PLEN - 1; k < W; k++)
      if (PLEN'(w >> (W - 1 - k)) == PAT) begin
        if (cnt == 0) first = k;
        cnt++;
      end
  endfunction
  function automatic int pick(input logic [NCH-1:0] v, input int rr);
    for (int i = 0; i < NCH; i++) if (v[(rr + i) % NCH]) return (rr + i) % NCH;
    return -1;
  endfunction
  task automatic step();
    int g, c, f;
    @(negedge clk);
    g = (reset || m_state != 0) ? -1 : pick(req_valid, m_rr);
    chk("req_ready", 32'(req_ready), g < 0 ? 32'd0 : 32'(1 << g));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_state == 2));
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("rsp_chan", 32'(rsp_chan), 32'(e_chan));
    chk("rsp_count", 32'(rsp_count), 32'(e_count));
    chk("rsp_hit", 32'(rsp_hit), 32'(e_hit));
    chk("rsp_first", 32'(rsp_first), 32'(e_first));
    if (reset) begin
      m_state = 0; m_rr = 0; e_chan = '0; e_count = '0; e_hit = 1'b0; e_first = '0;
    end else if (m_state == 0) begin
      if (g >= 0) begin
        m_chan = g; m_word = req_data[g*W +: W]; m_k = 0; m_state = 1;
      end
    end else if (m_state == 1) begin
      m_k++;
      if (m_k == W) begin
        scan(m_word, c, f);
        e_chan = IW'(m_chan); e_count = CW'(c); e_hit = c != 0; e_first = PW'(f); m_state = 2;
      end
    end else if (rsp_ready) begin
      m_rr = (m_chan + 1) % NCH; m_state = 0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 60) begin step(); lat++; end
    chk("rsp_wait", 32'(rsp_valid), 32'd1);
  endtask
  task automatic send(input int ch, input logic [W-1:0] d, output int lat);
    req_valid = NCH'(1) << ch;
    req_data[ch*W +: W] = d;
    step();
    req_valid = '0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin step(); lat++; end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  initial begin
    int lat, c, f;
    reset = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    m_state = 0; m_rr = 0; m_k = 0; m_chan = 0; m_word = '0;
    e_chan = '0; e_count = '0; e_hit = 1'b0; e_first = '0;
    @(posedge clk);
    #1;
    do_reset();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    scan(16'hB000, c, f); chk("model_b000_cnt", c, 1); chk("model_b000_first", f, 3);
    scan(16'hB6C0, c, f); chk("model_b6c0_cnt", c, 3); chk("model_b6c0_first", f, 3);
    scan(16'hB6DB, c, f); chk("model_b6db_cnt", c, 5);
    scan(16'h000D, c, f); chk("model_000d_cnt", c, 0);
    send(2, 16'hB000, lat);
    chk("lat", lat, 17);
    chk("b000_chan", 32'(rsp_chan), 2); chk("b000_count", 32'(rsp_count), 1);
    chk("b000_hit", 32'(rsp_hit), 1); chk("b000_first", 32'(rsp_first), 3);
    step();
    chk("b000_drop", 32'(rsp_valid), 0);
    send(0, 16'hB6C0, lat);
    chk("b6c0_count", 32'(rsp_count), 3); chk("b6c0_first", 32'(rsp_first), 3);
    step();
    send(1, 16'h000D, lat);
    chk("000d_count", 32'(rsp_count), 0); chk("000d_hit", 32'(rsp_hit), 0);
    step();
    send(1, 16'h6000, lat);
    chk("6000_count", 32'(rsp_count), 0); chk("6000_first", 32'(rsp_first), 0);
    step();
    rsp_ready = 1'b0;
    send(3, 16'hB6DB, lat);
    req_valid = '1;
    repeat (5) step();
    chk("hold_valid", 32'(rsp_valid), 1); chk("hold_ready", 32'(req_ready), 0);
    chk("hold_busy", 32'(busy), 1); chk("hold_chan", 32'(rsp_chan), 3);
    chk("hold_count", 32'(rsp_count), 5); chk("hold_first", 32'(rsp_first), 3);
    rsp_ready = 1'b1;
    req_valid = '0;
    step();
    chk("hold_drop", 32'(rsp_valid), 0);
    req_valid = '1;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      wait_rsp(lat);
      chk("rr_order", 32'(rsp_chan), n);
      step();
    end
    req_valid = 4'b1001;
    for (int n = 0; n < 2; n++) begin
      wait_rsp(lat);
      chk("rr_pair", 32'(rsp_chan), n == 0 ? 0 : 3);
      step();
    end
    req_valid = '0;
    step();
    req_valid = 4'b1000;
    req_data[3*W +: W] = 16'hB000;
    step();
    req_valid = '0;
    repeat (7) step();
    do_reset();
    chk("midreset_valid", 32'(rsp_valid), 0); chk("midreset_busy", 32'(busy), 0);
    req_valid = 4'b1010;
    wait_rsp(lat);
    chk("midreset_grant", 32'(rsp_chan), 1);
    req_valid = '0;
    step();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NCH; i++)
        req_data[i*W +: W] = ($urandom_range(0, 3) == 0) ? (16'hB6DB ^ 16'($urandom_range(0, 15))) : 16'($urandom);
      req_valid = NCH'($urandom);
      rsp_ready = $urandom_range(0, 2) != 0;
      reset = $urandom_range(0, 299) == 0;
      step();
    end
    reset = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_scan_sched.md
Name: seq_scan_sched

Overview:
- Shared-engine scheduler for the serial Mealy sequence detector.
- NCH requesters each present a W-bit word. The block arbitrates round-robin, serialises the granted word MSB-first into one pattern-match core, and counts overlapping matches.
- Returns count, first-match position and channel ID on a valid/ready response port.
- Sits between the parallel capture registers and the status/interrupt logic.

Parameters:
- NCH, 4, number of requesting channels (>=2)
- W, 16, bits per word
- PLEN, 4, pattern length (2..W)
- PATTERN, 4'b1011, pattern, MSB = first bit in time

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NCH  per-channel word valid
- req_data  in  NCH*W  channel i word at [i*W +: W]
- req_ready  out  NCH  one-hot accept strobe, combinational
- rsp_valid  out  1  result valid, held until accepted
- rsp_ready  in  1  result consumer ready
- rsp_chan  out  $clog2(NCH)  channel of result
- rsp_count  out  $clog2(W+1)  number of matches in word
- rsp_hit  out  1  rsp_count != 0
- rsp_first  out  $clog2(W)  bit index (0 = first serialised) completing first match; 0 when rsp_hit=0
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high, clk edge): state=IDLE; rr_ptr=0; bit counter, match counter and detector history cleared. rsp_valid, rsp_chan, rsp_count, rsp_hit, rsp_first and busy are all 0. req_ready is 0 while reset is high.
- IDLE:
  - grant = first channel with req_valid, searching from rr_ptr upward with wrap.
  - req_ready[grant]=1 for that cycle only (requires state==IDLE). Transfer completes when req_valid & req_ready are both high.
  - On transfer: latch word and channel, clear detector history and counters, go to SHIFT.
  - No valid: stay in IDLE with req_ready=0.
- SHIFT (exactly W cycles, bit index k=0..W-1):
  - Feed word[W-1-k] to the core.
  - Core is Mealy: match_k=1 when the last PLEN bits including bit k equal PATTERN. Overlapping matches count.
  - No match can complete before k=PLEN-1. History never spans words.
  - On match_k: count++. If this is the first match, first=k.
  - After k=W-1, go to RESP.
- RESP:
  - rsp_valid=1. rsp_chan, rsp_count, rsp_hit and rsp_first are registered and stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid & rsp_ready: rsp_valid=0 next cycle, rr_ptr=(chan+1) mod NCH, go to IDLE.
  - No grant in the same cycle as response acceptance.
- Latency: accept in cycle t; rsp_valid first high in cycle t+W+1. Minimum word period is W+2 cycles.
- Arbitration: strict round-robin, with no starvation for any channel holding req_valid. Requester may drop req_valid without penalty; only the IDLE-cycle sample matters.
- Counter width: $clog2(W+1) holds the count W-PLEN+1 without overflow.
- Reset mid-SHIFT or mid-RESP: word discarded, no response issued, next grant starts at channel 0.
- Simultaneous reset with req_valid: reset wins, no transfer.
- Outputs outside RESP: rsp_* fields hold last values, but rsp_valid=0.

Decomposition:
- Package seq_scan_pkg holds:
  - state enum {IDLE, SHIFT, RESP}
  - width localparams CW=$clog2(W+1), PW=$clog2(W), IW=$clog2(NCH)
  - default PATTERN/PLEN constants
- Sub-module seq_match_core (clk, reset, clr, bit_in, bit_en, match):
  - PLEN-1-bit history shift register plus Mealy compare.
  - clr has priority over bit_en.
- Round-robin grant stays inline.

Test Plan (defaults: NCH=4, W=16, PATTERN=1011):
- ch2 sends 16'hB000, rsp_ready=1 -> accept cycle t, rsp_valid at t+17; chan=2, count=1, hit=1, first=3.
- ch0 sends 16'hB6C0 (overlap 1011011011) -> count=3, first=3.
- ch1 sends 16'h000D (ends ...1101), then ch1 sends 16'h6000 (starts 011) -> both responses count=0, hit=0, first=0; no cross-word match.
- All four req_valid held high from reset -> grant order 0,1,2,3. Then ch0 and ch3 valid -> next grant 0, then 3.
- rsp_ready held low 5 cycles in RESP -> rsp_* stable, req_ready=0, busy=1; accept on cycle 6, rsp_valid=0 next cycle.
- reset pulsed at SHIFT bit 7 of ch3 word -> no rsp_valid; with ch3 and ch1 valid afterwards, first grant is ch1 (rr_ptr=0).
